// File: rtl/cpu_pkg.sv
// Shared CPU definitions: instruction field positions, fetch constants and
// the fetch-stage state type. The decoder imports the opfunc positions too.
package cpu_pkg;

  localparam int INSTR_W    = 32;
  localparam int OPFUNC_W   = 12;
  localparam int COND_MSB   = 31;
  localparam int COND_LSB   = 28;
  localparam int OPC_MSB    = 27;
  localparam int OPC_LSB    = 20;
  localparam int BR_OFF_W   = 24;
  localparam int PC_STEP    = 4;
  localparam int BR_PC_BIAS = 8;

  typedef enum logic {
    S_INIT,
    S_RUN
  } fetch_state_e;

  // {cond, opcode byte} slice handed to the decoder.
  function automatic logic [OPFUNC_W-1:0] opfunc_of(input logic [INSTR_W-1:0] instr);
    return {instr[COND_MSB:COND_LSB], instr[OPC_MSB:OPC_LSB]};
  endfunction

endpackage

// File: rtl/branch_target.sv
// Branch target adder: pc + 8 + (sign-extended word offset << 2).
// Wraps silently at ADDR_W bits. Shared with the execute stage.
module branch_target
  import cpu_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic [ADDR_W-1:0]   pc_i,
  input  logic [BR_OFF_W-1:0] offset_i,
  output logic [ADDR_W-1:0]   target_o
);

  logic [ADDR_W-1:0] off_ext;

  // Sign-extend the word offset, scale to bytes and add the pipeline bias.
  always_comb begin
    off_ext  = ADDR_W'(signed'(offset_i));
    target_o = pc_i + ADDR_W'(BR_PC_BIAS) + (off_ext << 2);
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the PC, issues single-outstanding word
// fetches, holds one instruction in the IF/ID buffer and redirects on a
// taken branch reported by the decoder.
module fetch_stage
  import cpu_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                clk,
  input  logic                rst,
  output logic                imem_req,
  output logic [ADDR_W-1:0]   imem_addr,
  input  logic                imem_ack,
  input  logic [INSTR_W-1:0]  imem_rdata,
  output logic                id_valid,
  input  logic                id_ready,
  output logic [INSTR_W-1:0]  id_instr,
  output logic [OPFUNC_W-1:0] id_opfunc,
  output logic [ADDR_W-1:0]   id_pc,
  output logic [ADDR_W-1:0]   id_link_addr,
  input  logic                pc_src
);

  fetch_state_e       state_q;
  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic [ADDR_W-1:0]  id_pc_q, id_pc_d;
  logic [INSTR_W-1:0] id_instr_q, id_instr_d;
  logic               id_valid_q, id_valid_d;
  logic [ADDR_W-1:0]  target;
  logic               consume, redirect, fire;

  assign consume  = id_valid_q & id_ready;
  assign redirect = consume & pc_src;

  // A request only goes out when the buffer is empty or draining, so an ack
  // always lands in a free slot; a taken branch suppresses it for one cycle.
  assign imem_req  = (state_q == S_RUN) & ~redirect & (~id_valid_q | id_ready);
  assign imem_addr = pc_q;
  assign fire      = imem_req & imem_ack;

  branch_target #(.ADDR_W(ADDR_W)) u_branch_target (
    .pc_i     (id_pc_q),
    .offset_i (id_instr_q[BR_OFF_W-1:0]),
    .target_o (target)
  );

  // Startup sequencer: one idle cycle after reset, then run until next reset.
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_INIT;
    else     state_q <= S_RUN;
  end

  // Next-state for the PC and IF/ID buffer.
  always_comb begin
    pc_d       = pc_q;
    id_pc_d    = id_pc_q;
    id_instr_d = id_instr_q;
    id_valid_d = id_valid_q;
    if (fire) begin
      id_instr_d = imem_rdata;
      id_pc_d    = pc_q;
      id_valid_d = 1'b1;
      pc_d       = pc_q + ADDR_W'(PC_STEP);
    end else if (consume) begin
      id_valid_d = 1'b0;
    end
    if (redirect) pc_d = target;
  end

  // PC and IF/ID buffer registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q       <= RESET_PC;
      id_pc_q    <= '0;
      id_instr_q <= '0;
      id_valid_q <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      id_pc_q    <= id_pc_d;
      id_instr_q <= id_instr_d;
      id_valid_q <= id_valid_d;
    end
  end

  assign id_valid     = id_valid_q;
  assign id_instr     = id_instr_q;
  assign id_pc        = id_pc_q;
  assign id_opfunc    = opfunc_of(id_instr_q);
  assign id_link_addr = id_pc_q + ADDR_W'(PC_STEP);

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios plus a randomized run, with a
// memory responder and a scoreboard that predicts the program-order stream.
module tb_fetch_stage;

  localparam logic [31:0] RESET_PC = 32'h0;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        id_valid;
  logic        id_ready = 1'b0;
  logic [31:0] id_instr;
  logic [11:0] id_opfunc;
  logic [31:0] id_pc;
  logic [31:0] id_link_addr;
  logic        pc_src = 1'b0;

  fetch_stage #(.ADDR_W(32), .RESET_PC(RESET_PC)) dut (
    .clk          (clk),
    .rst          (rst),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ack     (imem_ack),
    .imem_rdata   (imem_rdata),
    .id_valid     (id_valid),
    .id_ready     (id_ready),
    .id_instr     (id_instr),
    .id_opfunc    (id_opfunc),
    .id_pc        (id_pc),
    .id_link_addr (id_link_addr),
    .pc_src       (pc_src)
  );

  always #5 clk = ~clk;

  int          errors = 0;
  int          checks = 0;
  int          fixed_lat = 0;
  int          lat_max = 0;
  bit          spurious = 1'b0;
  int          wait_cnt = -1;
  bit          prev_pending = 1'b0;
  int          waits_seen = 0;
  int          n_consumed = 0;
  logic [31:0] req_addr = '0;
  logic [31:0] exp_q[$];

  // Instruction memory contents: a few fixed instructions for the directed
  // branch/stall scenarios, a hash everywhere else.
  function automatic logic [31:0] mem(input logic [31:0] a);
    case (a)
      32'h0000_0008: return 32'hE3A0_1005;
      32'h0000_000C: return 32'hEA00_003B;   // -> 0x100
      32'h0000_0100: return 32'hEAFF_FFFE;   // -> 0x100
      32'h0000_0104: return 32'hEAFF_FFC5;   // -> 0x20
      32'h0000_0020: return 32'hEB00_0002;   // -> 0x30
      default:       return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endcase
  endfunction

  function automatic logic [31:0] br_tgt(input logic [31:0] pc, input logic [31:0] ins);
    logic [31:0] off;
    off = {{8{ins[23]}}, ins[23:0]};
    return pc + 32'd8 + off * 32'd4;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Memory responder: latency per request, address stability, held request.
  always @(negedge clk) begin
    #1;
    if (rst) begin
      imem_ack     = 1'b0;
      wait_cnt     = -1;
      prev_pending = 1'b0;
    end else begin
      if (prev_pending) chk("req_held", {63'd0, imem_req}, 64'd1);
      if (imem_req) begin
        if (wait_cnt < 0) begin
          wait_cnt = (fixed_lat >= 0) ? fixed_lat : int'($urandom_range(lat_max, 0));
          req_addr = imem_addr;
        end else begin
          chk("addr_stable", {32'd0, imem_addr}, {32'd0, req_addr});
        end
        if (wait_cnt == 0) begin
          imem_ack     = 1'b1;
          imem_rdata   = mem(imem_addr);
          wait_cnt     = -1;
          prev_pending = 1'b0;
        end else begin
          imem_ack     = 1'b0;
          imem_rdata   = $urandom;
          wait_cnt     = wait_cnt - 1;
          waits_seen   = waits_seen + 1;
          prev_pending = 1'b1;
        end
      end else begin
        imem_ack     = spurious;
        imem_rdata   = $urandom;
        wait_cnt     = -1;
        prev_pending = 1'b0;
      end
    end
  end

  // Scoreboard monitor: each accepted instruction must be the next one in
  // program order; the branch decision given with it picks the successor.
  always @(negedge clk) begin
    logic [31:0] pc;
    logic [31:0] ins;
    #2;
    if (rst) begin
      exp_q.delete();
      exp_q.push_back(RESET_PC);
    end else if (id_valid && id_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_empty: got consume with no expected entry at %0t", $time);
      end else begin
        pc  = exp_q.pop_front();
        ins = mem(pc);
        chk("sb_id_pc",     {32'd0, id_pc},        {32'd0, pc});
        chk("sb_id_instr",  {32'd0, id_instr},     {32'd0, ins});
        chk("sb_id_opfunc", {52'd0, id_opfunc},    {52'd0, ins[31:20]});
        chk("sb_id_link",   {32'd0, id_link_addr}, {32'd0, pc + 32'd4});
        exp_q.push_back(pc_src ? br_tgt(pc, ins) : pc + 32'd4);
        n_consumed++;
      end
    end
  end

  task automatic cyc(input logic r, input logic s);
    @(negedge clk);
    id_ready = r;
    pc_src   = s;
    #3;
  endtask

  task automatic reset_dut();
    @(negedge clk);
    rst      = 1'b1;
    id_ready = 1'b1;
    pc_src   = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #3;
  endtask

  task automatic chk_req(input string name, input logic req, input logic [31:0] addr);
    chk({name, "_req"}, {63'd0, imem_req}, {63'd0, req});
    if (req) chk({name, "_addr"}, {32'd0, imem_addr}, {32'd0, addr});
  endtask

  initial begin
    // Reset values and zero-wait streaming.
    fixed_lat = 0;
    reset_dut();
    chk_req("rst", 1'b0, 32'h0);
    chk("rst_valid", {63'd0, id_valid}, 64'd0);
    chk("rst_instr", {32'd0, id_instr}, 64'd0);
    chk("rst_id_pc", {32'd0, id_pc},    64'd0);
    cyc(1'b1, 1'b0);
    chk_req("first", 1'b1, 32'h0);
    for (int i = 0; i < 3; i++) begin
      cyc(1'b1, 1'b0);
      chk("zw_valid", {63'd0, id_valid}, 64'd1);
      chk("zw_id_pc", {32'd0, id_pc}, 64'(4 * i));
      chk("zw_link",  {32'd0, id_link_addr}, 64'(4 * i + 4));
    end

    // Delayed ack on the second fetch.
    reset_dut();
    cyc(1'b1, 1'b0);
    fixed_lat  = 3;
    waits_seen = 0;
    cyc(1'b1, 1'b0);
    chk_req("dly0", 1'b1, 32'h4);
    for (int i = 0; i < 3; i++) begin
      cyc(1'b1, 1'b0);
      chk("dly_valid", {63'd0, id_valid}, 64'd0);
      chk_req("dly", 1'b1, 32'h4);
    end
    chk("dly_waits", 64'(waits_seen), 64'd3);
    fixed_lat = 0;
    cyc(1'b1, 1'b0);
    chk("dly_cap_valid", {63'd0, id_valid}, 64'd1);
    chk("dly_cap_pc",    {32'd0, id_pc}, 64'h4);

    // Stall with 0xE3A01005 buffered.
    for (int i = 0; i < 4; i++) begin
      cyc(1'b0, 1'b0);
      chk("stall_valid",  {63'd0, id_valid}, 64'd1);
      chk("stall_instr",  {32'd0, id_instr}, 64'hE3A0_1005);
      chk("stall_opfunc", {52'd0, id_opfunc}, 64'hE3A);
      chk("stall_id_pc",  {32'd0, id_pc}, 64'h8);
      chk_req("stall", 1'b0, 32'h0);
    end
    cyc(1'b1, 1'b0);
    chk_req("resume", 1'b1, 32'hC);

    // Branch chain: 0xC -> 0x100 -> 0x100 -> (fall through) 0x104 -> 0x20 -> 0x30.
    cyc(1'b1, 1'b1);
    chk("br_c_pc", {32'd0, id_pc}, 64'hC);
    chk_req("br_c", 1'b0, 32'h0);
    cyc(1'b1, 1'b0);
    chk("bubble_valid", {63'd0, id_valid}, 64'd0);
    chk_req("br_c_tgt", 1'b1, 32'h100);
    cyc(1'b1, 1'b1);
    chk("br_100_pc", {32'd0, id_pc}, 64'h100);
    chk_req("br_100", 1'b0, 32'h0);
    cyc(1'b1, 1'b0);
    chk_req("br_100_tgt", 1'b1, 32'h100);
    cyc(1'b1, 1'b0);
    chk("seq_100_pc", {32'd0, id_pc}, 64'h100);
    chk_req("seq_100", 1'b1, 32'h104);
    cyc(1'b1, 1'b1);
    chk_req("br_104", 1'b0, 32'h0);
    cyc(1'b1, 1'b0);
    chk_req("br_104_tgt", 1'b1, 32'h20);
    cyc(1'b1, 1'b1);
    chk("bl_pc",   {32'd0, id_pc}, 64'h20);
    chk("bl_link", {32'd0, id_link_addr}, 64'h24);
    chk_req("bl", 1'b0, 32'h0);
    cyc(1'b1, 1'b0);
    chk_req("bl_tgt", 1'b1, 32'h30);
    cyc(1'b0, 1'b1);
    chk("nored_valid", {63'd0, id_valid}, 64'd1);
    chk_req("nored_stall", 1'b0, 32'h0);
    cyc(1'b1, 1'b0);
    chk("nored_pc", {32'd0, id_pc}, 64'h30);
    chk_req("nored", 1'b1, 32'h34);

    // Randomized traffic against the scoreboard.
    fixed_lat = -1;
    lat_max   = 3;
    for (int i = 0; i < 2000; i++)
      cyc($urandom_range(9, 0) < 7, $urandom_range(4, 0) == 0);
    chk("rand_progress", {63'd0, n_consumed > 300}, 64'd1);

    // Reset while a fetch is pending, then a stray ack while idle.
    fixed_lat = 5;
    reset_dut();
    cyc(1'b1, 1'b0);
    chk_req("mw0", 1'b1, 32'h0);
    cyc(1'b1, 1'b0);
    chk_req("mw1", 1'b1, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    #3;
    @(negedge clk);
    rst      = 1'b0;
    spurious = 1'b1;
    #3;
    chk_req("mw_init", 1'b0, 32'h0);
    chk("mw_init_valid", {63'd0, id_valid}, 64'd0);
    fixed_lat = 0;
    cyc(1'b1, 1'b0);
    spurious = 1'b0;
    chk("mw_spur_valid", {63'd0, id_valid}, 64'd0);
    chk_req("mw_restart", 1'b1, RESET_PC);
    cyc(1'b1, 1'b0);
    chk("mw_cap_valid", {63'd0, id_valid}, 64'd1);
    chk("mw_cap_pc",    {32'd0, id_pc}, {32'd0, RESET_PC});
    chk("mw_cap_instr", {32'd0, id_instr}, {32'd0, mem(RESET_PC)});
    cyc(1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage directly upstream of the condition/opcode decoder.
- Owns the PC and issues word fetches to instruction memory over a req/ack handshake.
- Holds the fetched instruction in a one-entry IF/ID buffer and presents it with valid/ready, together with the 12-bit opfunc slice {cond, opcode byte} the decoder consumes.
- Takes the decoder's pc_src back and redirects the PC to the computed branch target.

Parameters:
- ADDR_W, 32, PC / instruction-address width in bits (byte address).
- RESET_PC, 0, first fetch address after reset; must be a multiple of 4.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- imem_req  out  1  fetch request, held until imem_ack.
- imem_addr  out  ADDR_W  fetch byte address; stable while imem_req=1.
- imem_ack  in  1  read data valid this cycle; may coincide with the first imem_req cycle.
- imem_rdata  in  32  instruction word.
- id_valid  out  1  IF/ID buffer holds a valid instruction.
- id_ready  in  1  downstream accepts the buffered instruction this cycle.
- id_instr  out  32  buffered instruction.
- id_opfunc  out  12  {id_instr[31:28], id_instr[27:20]}.
- id_pc  out  ADDR_W  address of the buffered instruction.
- id_link_addr  out  ADDR_W  id_pc+4, the return address written by BL.
- pc_src  in  1  decoder: take branch; meaningful only while id_valid=1.

Behaviour:
- Clocking and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: state=S_INIT, pc_q=RESET_PC, id_valid=0, id_instr=0, id_pc=0, imem_req=0.
- S_INIT: one cycle with no request, then S_RUN unconditionally. Only rst returns the block to S_INIT.
- Define consume = id_valid & id_ready.
- Define redirect = consume & pc_src.
- imem_req = (state==S_RUN) & ~redirect & (~id_valid | id_ready).
- imem_addr = pc_q.
- Single outstanding fetch:
  - A request is only raised when the buffer is empty or draining, so the buffer is always empty when imem_ack arrives.
  - Once raised with id_valid=0, imem_req stays high until ack, because nothing else can fill the buffer.
- imem_ack is sampled only when imem_req=1; ack while imem_req=0 is ignored. Imem shares rst, so no stale ack survives reset.
- On imem_req & imem_ack:
  - id_instr<=imem_rdata, id_pc<=pc_q, id_valid<=1.
  - pc_q<=pc_q+4, modulo 2^ADDR_W.
- On consume without ack: id_valid<=0.
- On consume and ack in the same cycle: buffer reloads, id_valid stays 1. Zero-wait memory with id_ready=1 sustains 1 instruction/cycle.
- On redirect:
  - imem_req=0 that cycle.
  - id_valid<=0.
  - pc_q<=target, where target = id_pc + 8 + (sign_extend(id_instr[23:0]) << 2), truncated to ADDR_W, wrapping silently.
  - The first fetch from target is issued the next cycle (one-bubble branch penalty).
- pc_src while id_valid=0 or id_ready=0: no effect.
- id_valid=1 and id_ready=0: all id_* outputs hold, and no request is issued.
- id_opfunc and id_link_addr are combinational from the buffer registers.
- rst mid-wait (imem_req high, no ack): request dropped next cycle, pc_q=RESET_PC, buffer cleared.
- No unaligned handling: pc_q[1:0] is always 00 by construction.

Decomposition:
- Shared package cpu_pkg:
  - INSTR_W=32.
  - OPFUNC_W=12.
  - COND_MSB/LSB=31/28.
  - OPC_MSB/LSB=27/20.
  - BR_OFF_W=24.
  - State enum {S_INIT, S_RUN}.
  - PC_STEP=4.
  - BR_PC_BIAS=8.
- The decoder also imports the opfunc field positions from cpu_pkg.
- One sub-module is natural: branch_target (combinational; id_pc + id_instr[23:0] -> target), reused later by the execute stage.

Test Plan:
- Reset then zero-wait imem (ack same cycle as req), id_ready=1:
  - first imem_req in cycle 2 after rst release, addr 0x0.
  - id_pc sequence 0x0, 0x4, 0x8 on consecutive cycles.
  - id_link_addr 0x4, 0x8, 0xC.
- imem ack delayed 3 cycles: imem_req and imem_addr=0x4 held stable for 3 cycles; id_valid=0 throughout; exactly one capture.
- id_ready=0 for 4 cycles with instruction 0xE3A01005 buffered:
  - id_instr and id_opfunc=0xE3A held.
  - imem_req=0.
  - Fetch resumes at the next address when id_ready rises.
- Branch 0xEAFFFFFE at id_pc=0x100 with pc_src=1: no request that cycle; next imem_addr=0x100 (target = 0x100+8-8).
- Branch 0xEB000002 at 0x20 with pc_src=1: next imem_addr=0x30 and id_link_addr=0x24 in the redirect cycle.
- pc_src=1 while id_ready=0: no redirect.
- pc_src=0: sequential fetch continues.
- rst asserted while imem_req is pending: a later spurious ack with imem_req=0 is ignored; fetch restarts at RESET_PC.
